// File: rtl/mem_req_arbiter.sv
// Read/write request arbiter between the L1 requesters and the single AXI burst bridge.
// Independent read and write FSMs; reads are held off while a write to the same line is in flight.
module mem_req_arbiter #(
    parameter int LINE_BEATS = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_rreq_i,
    input  logic        dc_rreq_i,
    input  logic        uc_rreq_i,
    input  logic [31:0] ic_raddr_i,
    input  logic [31:0] dc_raddr_i,
    input  logic [31:0] uc_raddr_i,
    output logic        ic_rgnt_o,
    output logic        dc_rgnt_o,
    output logic        uc_rgnt_o,
    output logic        ic_rvalid_o,
    output logic        dc_rvalid_o,
    output logic        uc_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        ic_rdone_o,
    output logic        dc_rdone_o,
    output logic        uc_rdone_o,
    input  logic        dc_wreq_i,
    input  logic [31:0] dc_waddr_i,
    input  logic        uc_wreq_i,
    input  logic [31:0] uc_waddr_i,
    input  logic [3:0]  uc_wstrb_i,
    output logic        dc_wgnt_o,
    output logic        uc_wgnt_o,
    output logic        dc_wdone_o,
    output logic        uc_wdone_o,
    output logic        bus_rreq_o,
    output logic [31:0] bus_raddr_o,
    output logic [7:0]  bus_rlen_o,
    input  logic        bus_rvalid_i,
    input  logic        bus_rlast_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_wreq_o,
    output logic [31:0] bus_waddr_o,
    output logic [7:0]  bus_wlen_o,
    output logic [3:0]  bus_wstrb_o,
    output logic        bus_wsrc_o,
    input  logic        bus_bresp_i
);
    // state  | meaning
    // R_IDLE | no read outstanding; arbitrating among unblocked readers
    // R_BUSY | line/uncached read in flight for r_owner
    // W_IDLE | no write outstanding; arbitrating dcache > uncached
    // W_BUSY | write in flight, waiting for bus_bresp_i
    typedef enum logic {R_IDLE, R_BUSY} r_state_t;
    typedef enum logic {W_IDLE, W_BUSY} w_state_t;
    typedef enum logic [1:0] {OWN_IC, OWN_DC, OWN_UC} owner_t;

    localparam logic [7:0]  LINE_LEN   = 8'(LINE_BEATS - 1);
    localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [31:0] LINE_MASK  = 32'hFFFF_FFF0;

    r_state_t    r_state, r_state_d;
    w_state_t    w_state, w_state_d;
    owner_t      r_owner;
    logic [27:0] w_line;
    logic [2:0]  ic_wait;

    logic        w_win_dc, w_win_uc, w_win;
    logic [31:0] w_new_addr;
    logic        ic_ok, dc_ok, uc_ok;
    logic        r_win_ic, r_win_dc, r_win_uc, r_win;
    logic        r_last;

    assign w_win      = w_win_dc | w_win_uc;
    assign w_new_addr = dc_wreq_i ? dc_waddr_i : uc_waddr_i;

    // A read is blocked by the line of a write in flight or one being granted right now.
    assign ic_ok = ic_rreq_i &&
        !((w_state == W_BUSY && ic_raddr_i[31:4] == w_line) || (w_win && ic_raddr_i[31:4] == w_new_addr[31:4]));
    assign dc_ok = dc_rreq_i &&
        !((w_state == W_BUSY && dc_raddr_i[31:4] == w_line) || (w_win && dc_raddr_i[31:4] == w_new_addr[31:4]));
    assign uc_ok = uc_rreq_i &&
        !((w_state == W_BUSY && uc_raddr_i[31:4] == w_line) || (w_win && uc_raddr_i[31:4] == w_new_addr[31:4]));

    assign r_last = (r_state == R_BUSY) && bus_rvalid_i && bus_rlast_i;
    assign r_win  = r_win_ic | r_win_dc | r_win_uc;

    always_comb begin
        w_win_dc  = 1'b0;
        w_win_uc  = 1'b0;
        w_state_d = w_state;
        case (w_state)
            W_IDLE: begin
                if (dc_wreq_i) begin
                    w_win_dc  = 1'b1;
                    w_state_d = W_BUSY;
                end else if (uc_wreq_i) begin
                    w_win_uc  = 1'b1;
                    w_state_d = W_BUSY;
                end
            end
            W_BUSY: if (bus_bresp_i) w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_win_ic  = 1'b0;
        r_win_dc  = 1'b0;
        r_win_uc  = 1'b0;
        r_state_d = r_state;
        case (r_state)
            R_IDLE: begin
                if (ic_ok && ic_wait >= STARVE_LIM) r_win_ic = 1'b1;
                else if (dc_ok)                     r_win_dc = 1'b1;
                else if (uc_ok)                     r_win_uc = 1'b1;
                else if (ic_ok)                     r_win_ic = 1'b1;
                if (r_win_ic || r_win_dc || r_win_uc) r_state_d = R_BUSY;
            end
            R_BUSY: if (r_last) r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_state_d;
            w_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= OWN_IC;
            ic_wait     <= 3'd0;
            w_line      <= 28'd0;
            ic_rgnt_o   <= 1'b0;
            dc_rgnt_o   <= 1'b0;
            uc_rgnt_o   <= 1'b0;
            ic_rdone_o  <= 1'b0;
            dc_rdone_o  <= 1'b0;
            uc_rdone_o  <= 1'b0;
            dc_wgnt_o   <= 1'b0;
            uc_wgnt_o   <= 1'b0;
            dc_wdone_o  <= 1'b0;
            uc_wdone_o  <= 1'b0;
            bus_raddr_o <= 32'd0;
            bus_rlen_o  <= 8'd0;
            bus_waddr_o <= 32'd0;
            bus_wlen_o  <= 8'd0;
            bus_wstrb_o <= 4'd0;
            bus_wsrc_o  <= 1'b0;
        end else begin
            ic_rgnt_o  <= r_win_ic;
            dc_rgnt_o  <= r_win_dc;
            uc_rgnt_o  <= r_win_uc;
            ic_rdone_o <= r_last && r_owner == OWN_IC;
            dc_rdone_o <= r_last && r_owner == OWN_DC;
            uc_rdone_o <= r_last && r_owner == OWN_UC;
            if (r_win) begin
                r_owner     <= r_win_ic ? OWN_IC : (r_win_dc ? OWN_DC : OWN_UC);
                bus_raddr_o <= r_win_ic ? (ic_raddr_i & LINE_MASK)
                             : (r_win_dc ? (dc_raddr_i & LINE_MASK) : uc_raddr_i);
                bus_rlen_o  <= r_win_uc ? 8'd0 : LINE_LEN;
            end
            if (r_win_ic)
                ic_wait <= 3'd0;
            else if (ic_ok && (r_win_dc || r_win_uc) && ic_wait != 3'h7)
                ic_wait <= ic_wait + 3'd1;

            dc_wgnt_o  <= w_win_dc;
            uc_wgnt_o  <= w_win_uc;
            dc_wdone_o <= (w_state == W_BUSY) && bus_bresp_i && !bus_wsrc_o;
            uc_wdone_o <= (w_state == W_BUSY) && bus_bresp_i && bus_wsrc_o;
            if (w_win) begin
                w_line      <= w_new_addr[31:4];
                bus_waddr_o <= w_win_dc ? (dc_waddr_i & LINE_MASK) : uc_waddr_i;
                bus_wlen_o  <= w_win_dc ? LINE_LEN : 8'd0;
                bus_wstrb_o <= w_win_dc ? 4'hF : uc_wstrb_i;
                bus_wsrc_o  <= w_win_uc;
            end
        end
    end

    assign bus_rreq_o  = (r_state == R_BUSY);
    assign bus_wreq_o  = (w_state == W_BUSY);
    assign ic_rvalid_o = bus_rvalid_i && r_state == R_BUSY && r_owner == OWN_IC;
    assign dc_rvalid_o = bus_rvalid_i && r_state == R_BUSY && r_owner == OWN_DC;
    assign uc_rvalid_o = bus_rvalid_i && r_state == R_BUSY && r_owner == OWN_UC;
    assign rdata_o     = bus_rdata_i;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: randomized scenarios checked against
// a behavioural arbitration model (pending set + starvation count) kept here.
`timescale 1ns/1ps
module tb_mem_req_arbiter;
    localparam int LINE_BEATS = 4;
    localparam int STARVE_MAX = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ic_rreq_i = 0, dc_rreq_i = 0, uc_rreq_i = 0;
    logic [31:0] ic_raddr_i = 0, dc_raddr_i = 0, uc_raddr_i = 0;
    logic        ic_rgnt_o, dc_rgnt_o, uc_rgnt_o;
    logic        ic_rvalid_o, dc_rvalid_o, uc_rvalid_o;
    logic [31:0] rdata_o;
    logic        ic_rdone_o, dc_rdone_o, uc_rdone_o;
    logic        dc_wreq_i = 0, uc_wreq_i = 0;
    logic [31:0] dc_waddr_i = 0, uc_waddr_i = 0;
    logic [3:0]  uc_wstrb_i = 0;
    logic        dc_wgnt_o, uc_wgnt_o, dc_wdone_o, uc_wdone_o;
    logic        bus_rreq_o;
    logic [31:0] bus_raddr_o;
    logic [7:0]  bus_rlen_o;
    logic        bus_rvalid_i = 0, bus_rlast_i = 0;
    logic [31:0] bus_rdata_i = 0;
    logic        bus_wreq_o;
    logic [31:0] bus_waddr_o;
    logic [7:0]  bus_wlen_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_wsrc_o;
    logic        bus_bresp_i = 0;

    mem_req_arbiter #(.LINE_BEATS(LINE_BEATS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .ic_rreq_i(ic_rreq_i), .dc_rreq_i(dc_rreq_i), .uc_rreq_i(uc_rreq_i),
        .ic_raddr_i(ic_raddr_i), .dc_raddr_i(dc_raddr_i), .uc_raddr_i(uc_raddr_i),
        .ic_rgnt_o(ic_rgnt_o), .dc_rgnt_o(dc_rgnt_o), .uc_rgnt_o(uc_rgnt_o),
        .ic_rvalid_o(ic_rvalid_o), .dc_rvalid_o(dc_rvalid_o), .uc_rvalid_o(uc_rvalid_o),
        .rdata_o(rdata_o),
        .ic_rdone_o(ic_rdone_o), .dc_rdone_o(dc_rdone_o), .uc_rdone_o(uc_rdone_o),
        .dc_wreq_i(dc_wreq_i), .dc_waddr_i(dc_waddr_i),
        .uc_wreq_i(uc_wreq_i), .uc_waddr_i(uc_waddr_i), .uc_wstrb_i(uc_wstrb_i),
        .dc_wgnt_o(dc_wgnt_o), .uc_wgnt_o(uc_wgnt_o), .dc_wdone_o(dc_wdone_o), .uc_wdone_o(uc_wdone_o),
        .bus_rreq_o(bus_rreq_o), .bus_raddr_o(bus_raddr_o), .bus_rlen_o(bus_rlen_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rlast_i(bus_rlast_i), .bus_rdata_i(bus_rdata_i),
        .bus_wreq_o(bus_wreq_o), .bus_waddr_o(bus_waddr_o), .bus_wlen_o(bus_wlen_o),
        .bus_wstrb_o(bus_wstrb_o), .bus_wsrc_o(bus_wsrc_o), .bus_bresp_i(bus_bresp_i)
    );

    always #5 clk = ~clk;

    // Requester vectors: bit0 icache, bit1 dcache, bit2 uncached.
    logic [2:0]   rgnt, rvalid, rdone;
    logic [131:0] all_outs;
    assign rgnt   = {uc_rgnt_o, dc_rgnt_o, ic_rgnt_o};
    assign rvalid = {uc_rvalid_o, dc_rvalid_o, ic_rvalid_o};
    assign rdone  = {uc_rdone_o, dc_rdone_o, ic_rdone_o};
    assign all_outs = {rgnt, rvalid, rdone, rdata_o, dc_wgnt_o, uc_wgnt_o, dc_wdone_o, uc_wdone_o,
                       bus_rreq_o, bus_raddr_o, bus_rlen_o, bus_wreq_o, bus_waddr_o, bus_wlen_o,
                       bus_wstrb_o, bus_wsrc_o};

    int n_tests = 0;
    int n_fail  = 0;
    int ref_wait = 0;

    function automatic logic [2:0] ref_pick(input logic [2:0] pend, input int waitc);
        if (pend[0] && waitc >= STARVE_MAX) return 3'b001;
        if (pend[1]) return 3'b010;
        if (pend[2]) return 3'b100;
        if (pend[0]) return 3'b001;
        return 3'b000;
    endfunction

    function automatic void ref_update(input logic [2:0] pend, input logic [2:0] win);
        if (win[0]) ref_wait = 0;
        else if (pend[0] && win != 3'b000 && ref_wait < 7) ref_wait = ref_wait + 1;
    endfunction

    function automatic logic [31:0] ref_raddr(input logic [2:0] win, input logic [31:0] a);
        return win[2] ? a : (a / 16) * 16;
    endfunction

    function automatic logic [7:0] ref_rlen(input logic [2:0] win);
        return win[2] ? 8'd0 : 8'(LINE_BEATS - 1);
    endfunction

    task automatic wait_rgnt(output int cyc, output logic [2:0] who);
        cyc = -1;
        who = 3'b000;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (rgnt != 3'b000) begin
                cyc = i;
                who = rgnt;
                break;
            end
        end
    endtask

    // Drives a burst with random gaps; returns on the cycle after the last beat.
    task automatic serve_read(input int nbeats, output int rv_cnt, output logic [2:0] rv_who);
        int gap;
        rv_cnt = 0;
        rv_who = 3'b000;
        for (int b = 0; b < nbeats; b++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            bus_rdata_i  = $urandom;
            bus_rvalid_i = 1'b1;
            bus_rlast_i  = (b == nbeats - 1);
            #1;
            if (rvalid != 3'b000) rv_cnt++;
            rv_who |= rvalid;
            @(negedge clk);
            bus_rvalid_i = 1'b0;
            bus_rlast_i  = 1'b0;
            bus_rdata_i  = 32'd0;
        end
    endtask

    task automatic pulse_bresp();
        bus_bresp_i = 1'b1;
        @(negedge clk);
        bus_bresp_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected all zero", all_outs);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h, expected all zero", all_outs);
        end
        ref_wait = 0;
    endtask

    task automatic test_single_read();
        logic [31:0] data;
        int gap;
        ic_raddr_i = 32'h1C00_0014;
        ic_rreq_i  = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rgnt, bus_rreq_o, bus_raddr_o, bus_rlen_o} !== {3'b001, 1'b1, ref_raddr(3'b001, 32'h1C00_0014), ref_rlen(3'b001)}) begin
            n_fail++;
            $display("FAIL single_grant: got gnt %b rreq %b addr %h len %0d, expected 001 1 %h 3",
                     rgnt, bus_rreq_o, bus_raddr_o, bus_rlen_o, ref_raddr(3'b001, 32'h1C00_0014));
        end
        ic_rreq_i = 1'b0;
        ref_update(3'b001, 3'b001);
        @(negedge clk);
        n_tests++;
        if (rgnt !== 3'b000 || bus_rreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant_pulse: got gnt %b rreq %b, expected 000 1", rgnt, bus_rreq_o);
        end
        for (int b = 0; b < LINE_BEATS; b++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            data = $urandom;
            bus_rdata_i  = data;
            bus_rvalid_i = 1'b1;
            bus_rlast_i  = (b == LINE_BEATS - 1);
            #1;
            n_tests++;
            if ({rvalid, rdata_o, bus_rreq_o} !== {3'b001, data, 1'b1}) begin
                n_fail++;
                $display("FAIL single_beat%0d: got rvalid %b data %h rreq %b, expected 001 %h 1",
                         b, rvalid, rdata_o, bus_rreq_o, data);
            end
            @(negedge clk);
            bus_rvalid_i = 1'b0;
            bus_rlast_i  = 1'b0;
        end
        n_tests++;
        if (rdone !== 3'b001 || bus_rreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rdone: got rdone %b rreq %b, expected 001 0", rdone, bus_rreq_o);
        end
        @(negedge clk);
        n_tests++;
        if (rdone !== 3'b000) begin
            n_fail++;
            $display("FAIL single_rdone_pulse: got %b, expected 000", rdone);
        end
    endtask

    task automatic test_priority();
        logic [2:0]  pend, exp, who, rvw;
        logic [31:0] a [3];
        int cyc, cnt, nb;
        for (int r = 0; r < 3; r++) a[r] = $urandom;
        ic_raddr_i = a[0]; dc_raddr_i = a[1]; uc_raddr_i = a[2];
        ic_rreq_i = 1'b1; dc_rreq_i = 1'b1; uc_rreq_i = 1'b1;
        pend = 3'b111;
        for (int k = 0; k < 3; k++) begin
            exp = ref_pick(pend, ref_wait);
            wait_rgnt(cyc, who);
            n_tests++;
            if (who !== exp || cyc != 1) begin
                n_fail++;
                $display("FAIL priority_grant%0d: got %b after %0d cycles, expected %b after 1", k, who, cyc, exp);
            end
            n_tests++;
            if (bus_raddr_o !== ref_raddr(exp, a[exp[2] ? 2 : (exp[1] ? 1 : 0)]) || bus_rlen_o !== ref_rlen(exp)) begin
                n_fail++;
                $display("FAIL priority_cmd%0d: got addr %h len %0d, expected %h %0d", k, bus_raddr_o, bus_rlen_o,
                         ref_raddr(exp, a[exp[2] ? 2 : (exp[1] ? 1 : 0)]), ref_rlen(exp));
            end
            ref_update(pend, exp);
            pend = pend & ~exp;
            ic_rreq_i = pend[0]; dc_rreq_i = pend[1]; uc_rreq_i = pend[2];
            nb = exp[2] ? 1 : LINE_BEATS;
            serve_read(nb, cnt, rvw);
            n_tests++;
            if (rdone !== exp || rvw !== exp || cnt != nb) begin
                n_fail++;
                $display("FAIL priority_done%0d: got rdone %b rvalid-owner %b beats %0d, expected %b %b %0d",
                         k, rdone, rvw, cnt, exp, exp, nb);
            end
        end
    endtask

    task automatic test_starvation();
        logic [2:0] exp, who, rvw;
        int cyc, cnt, ic_wins;
        ic_raddr_i = $urandom;
        dc_raddr_i = ic_raddr_i ^ 32'h0000_0100;
        ic_rreq_i = 1'b1;
        dc_rreq_i = 1'b1;
        ic_wins = 0;
        for (int k = 0; k < 2 * (STARVE_MAX + 1); k++) begin
            exp = ref_pick(3'b011, ref_wait);
            wait_rgnt(cyc, who);
            n_tests++;
            if (who !== exp) begin
                n_fail++;
                $display("FAIL starve_grant%0d: got %b, expected %b (model wait %0d)", k, who, exp, ref_wait);
            end
            if (who == 3'b001) ic_wins++;
            ref_update(3'b011, exp);
            if (k == 2 * (STARVE_MAX + 1) - 1) begin
                ic_rreq_i = 1'b0;
                dc_rreq_i = 1'b0;
            end
            serve_read(LINE_BEATS, cnt, rvw);
            n_tests++;
            if (rdone !== exp) begin
                n_fail++;
                $display("FAIL starve_done%0d: got %b, expected %b", k, rdone, exp);
            end
        end
        n_tests++;
        if (ic_wins != 2) begin
            n_fail++;
            $display("FAIL starve_ic_count: got %0d icache grants, expected 2", ic_wins);
        end
    endtask

    task automatic test_hazard();
        logic [31:0] wa, ra;
        logic [2:0]  seen, rvw;
        int hold, cnt;
        for (int it = 0; it < 2; it++) begin
            if (it == 0) begin
                wa = 32'h0000_1230;
                ra = 32'h0000_1238;
            end else begin
                wa = $urandom;
                ra = {wa[31:4], 4'($urandom_range(0, 15))};
            end
            dc_wreq_i  = 1'b1;
            dc_waddr_i = wa;
            @(negedge clk);
            n_tests++;
            if ({dc_wgnt_o, uc_wgnt_o, bus_wreq_o, bus_waddr_o, bus_wlen_o, bus_wstrb_o, bus_wsrc_o} !==
                {1'b1, 1'b0, 1'b1, (wa / 16) * 16, 8'(LINE_BEATS - 1), 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL hazard_wcmd%0d: got gnt %b%b wreq %b addr %h len %0d strb %h src %b, expected 10 1 %h 3 f 0",
                         it, dc_wgnt_o, uc_wgnt_o, bus_wreq_o, bus_waddr_o, bus_wlen_o, bus_wstrb_o, bus_wsrc_o, (wa / 16) * 16);
            end
            dc_wreq_i  = 1'b0;
            dc_raddr_i = ra;
            dc_rreq_i  = 1'b1;
            seen = 3'b000;
            hold = $urandom_range(3, 8);
            repeat (hold) begin
                @(negedge clk);
                seen |= rgnt;
            end
            n_tests++;
            if (seen !== 3'b000 || bus_waddr_o !== (wa / 16) * 16 || bus_wreq_o !== 1'b1) begin
                n_fail++;
                $display("FAIL hazard_block%0d: got rgnt-seen %b waddr %h wreq %b, expected 000 %h 1",
                         it, seen, bus_waddr_o, bus_wreq_o, (wa / 16) * 16);
            end
            pulse_bresp();
            n_tests++;
            if ({dc_wdone_o, uc_wdone_o, rgnt, bus_wreq_o} !== {1'b1, 1'b0, 3'b000, 1'b0}) begin
                n_fail++;
                $display("FAIL hazard_wdone%0d: got wdone %b%b rgnt %b wreq %b, expected 10 000 0",
                         it, dc_wdone_o, uc_wdone_o, rgnt, bus_wreq_o);
            end
            @(negedge clk);
            n_tests++;
            if (rgnt !== 3'b010 || bus_raddr_o !== (ra / 16) * 16 || dc_wdone_o !== 1'b0) begin
                n_fail++;
                $display("FAIL hazard_rgnt%0d: got rgnt %b addr %h wdone %b, expected 010 %h 0",
                         it, rgnt, bus_raddr_o, dc_wdone_o, (ra / 16) * 16);
            end
            dc_rreq_i = 1'b0;
            ref_update(3'b010, 3'b010);
            serve_read(LINE_BEATS, cnt, rvw);
            n_tests++;
            if (rdone !== 3'b010 || rvw !== 3'b010) begin
                n_fail++;
                $display("FAIL hazard_rdone%0d: got rdone %b owner %b, expected 010 010", it, rdone, rvw);
            end
        end
        pulse_bresp();
        n_tests++;
        if ({dc_wdone_o, uc_wdone_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_bresp: got wdone %b%b, expected 00", dc_wdone_o, uc_wdone_o);
        end
    endtask

    task automatic test_uc_store();
        logic [31:0] wa, d;
        wa = $urandom;
        uc_waddr_i = wa;
        uc_wstrb_i = 4'b0011;
        uc_wreq_i  = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({dc_wgnt_o, uc_wgnt_o, bus_waddr_o, bus_wlen_o, bus_wstrb_o, bus_wsrc_o} !==
            {1'b0, 1'b1, wa, 8'd0, 4'b0011, 1'b1}) begin
            n_fail++;
            $display("FAIL uc_store_cmd: got gnt %b%b addr %h len %0d strb %b src %b, expected 01 %h 0 0011 1",
                     dc_wgnt_o, uc_wgnt_o, bus_waddr_o, bus_wlen_o, bus_wstrb_o, bus_wsrc_o, wa);
        end
        uc_wreq_i = 1'b0;
        d = $urandom;
        bus_rdata_i  = d;
        bus_rvalid_i = 1'b1;
        bus_rlast_i  = 1'b1;
        #1;
        n_tests++;
        if (rvalid !== 3'b000 || rdata_o !== d) begin
            n_fail++;
            $display("FAIL stray_rvalid: got rvalid %b data %h, expected 000 %h", rvalid, rdata_o, d);
        end
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        bus_rlast_i  = 1'b0;
        bus_rdata_i  = 32'd0;
        n_tests++;
        if (rdone !== 3'b000 || bus_rreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_rdone: got rdone %b rreq %b, expected 000 0", rdone, bus_rreq_o);
        end
        pulse_bresp();
        n_tests++;
        if ({dc_wdone_o, uc_wdone_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL uc_wdone: got %b%b, expected 01", dc_wdone_o, uc_wdone_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] wa, ra;
        logic [2:0]  rvw;
        int cnt;
        // same line: write wins, read waits for W_IDLE
        wa = $urandom;
        ra = {wa[31:4], 4'h8};
        dc_waddr_i = wa; dc_wreq_i = 1'b1;
        uc_raddr_i = ra; uc_rreq_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({dc_wgnt_o, rgnt} !== {1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL same_line: got wgnt %b rgnt %b, expected 1 000", dc_wgnt_o, rgnt);
        end
        dc_wreq_i = 1'b0;
        repeat (2) @(negedge clk);
        pulse_bresp();
        @(negedge clk);
        n_tests++;
        if (rgnt !== 3'b100 || bus_raddr_o !== ra || bus_rlen_o !== 8'd0) begin
            n_fail++;
            $display("FAIL same_line_rgnt: got rgnt %b addr %h len %0d, expected 100 %h 0", rgnt, bus_raddr_o, bus_rlen_o, ra);
        end
        uc_rreq_i = 1'b0;
        serve_read(1, cnt, rvw);
        // different lines: both granted together
        ra = $urandom;
        wa = ra ^ 32'h0001_0000;
        ic_raddr_i = ra; ic_rreq_i = 1'b1;
        uc_waddr_i = wa; uc_wstrb_i = 4'($urandom_range(0, 15)); uc_wreq_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rgnt, uc_wgnt_o, bus_raddr_o, bus_waddr_o} !== {3'b001, 1'b1, (ra / 16) * 16, wa}) begin
            n_fail++;
            $display("FAIL diff_line: got rgnt %b wgnt %b raddr %h waddr %h, expected 001 1 %h %h",
                     rgnt, uc_wgnt_o, bus_raddr_o, bus_waddr_o, (ra / 16) * 16, wa);
        end
        ic_rreq_i = 1'b0;
        uc_wreq_i = 1'b0;
        ref_update(3'b001, 3'b001);
        serve_read(LINE_BEATS, cnt, rvw);
        pulse_bresp();
        n_tests++;
        if ({uc_wdone_o, rdone} !== {1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL diff_line_done: got uc_wdone %b rdone %b, expected 1 000", uc_wdone_o, rdone);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] rvw;
        int cnt;
        ic_raddr_i = $urandom;
        ic_rreq_i  = 1'b1;
        @(negedge clk);
        serve_read(2, cnt, rvw);
        n_tests++;
        if (rvw !== 3'b001 || cnt != 2) begin
            n_fail++;
            $display("FAIL mid_burst_beats: got owner %b beats %0d, expected 001 2", rvw, cnt);
        end
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'd0;
        rst = 1'b0;
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL mid_burst_reset: got %h, expected all zero", all_outs);
        end
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        rst = 1'b1;
        ref_wait = 0;
        @(negedge clk);
        n_tests++;
        if (rgnt !== 3'b001 || rdone !== 3'b000) begin
            n_fail++;
            $display("FAIL regrant_after_reset: got rgnt %b rdone %b, expected 001 000", rgnt, rdone);
        end
        ic_rreq_i = 1'b0;
        serve_read(LINE_BEATS, cnt, rvw);
        n_tests++;
        if (rdone !== 3'b001) begin
            n_fail++;
            $display("FAIL regrant_done: got %b, expected 001", rdone);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_starvation();
        test_hazard();
        test_uc_store();
        test_simultaneous();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Request arbiter and scheduler between the L1 caches/uncached path and the single AXI burst bridge. Arbitrates three read requesters (icache line fill, dcache line fill, uncached load) onto one read channel and two write requesters (dcache writeback, uncached store) onto one write channel, with a read-after-write line hazard check. Routes returned read beats and completion pulses back to the owning requester. Holds no data; write data is selected downstream via `bus_wsrc_o`.

## Interface
- `LINE_BEATS`, default 4: 32-bit beats per cache line (16-byte line); line burst `rlen`/`wlen` = `LINE_BEATS-1`.
- `STARVE_MAX`, default 7: consecutive icache losses before icache is promoted.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `ic_rreq_i` / `dc_rreq_i` / `uc_rreq_i`  in  1 each  read request; level, held until the matching grant
- `ic_raddr_i` / `dc_raddr_i` / `uc_raddr_i`  in  32 each  read address
- `ic_rgnt_o` / `dc_rgnt_o` / `uc_rgnt_o`  out  1 each  grant pulse, one cycle
- `ic_rvalid_o` / `dc_rvalid_o` / `uc_rvalid_o`  out  1 each  returned beat valid for that owner
- `rdata_o`  out  32  returned beat data, equal to `bus_rdata_i`
- `ic_rdone_o` / `dc_rdone_o` / `uc_rdone_o`  out  1 each  transfer-complete pulse
- `dc_wreq_i`, `dc_waddr_i[31:0]`  in  dcache writeback request and address
- `uc_wreq_i`, `uc_waddr_i[31:0]`, `uc_wstrb_i[3:0]`  in  uncached store request, address and strobe
- `dc_wgnt_o`, `uc_wgnt_o`, `dc_wdone_o`, `uc_wdone_o`  out  1 each  write grant / complete pulses
- `bus_rreq_o`  out  1; `bus_raddr_o`  out  32; `bus_rlen_o`  out  8: read command to the bridge
- `bus_rvalid_i`, `bus_rlast_i`  in  1 each; `bus_rdata_i`  in  32: read beats
- `bus_wreq_o`  out  1; `bus_waddr_o`  out  32; `bus_wlen_o`  out  8; `bus_wstrb_o`  out  4; `bus_wsrc_o`  out  1 (0 = dcache, 1 = uncached): write command
- `bus_bresp_i`  in  1: write complete, one pulse per write transaction

## Operation
- Read FSM has two states, R_IDLE and R_BUSY. Write FSM has two states, W_IDLE and W_BUSY. The two FSMs run independently.
- **Read arbitration** (in R_IDLE only), among unblocked requesters:
  - If `ic_wait` = `STARVE_MAX`, icache wins.
  - Otherwise priority is dcache > uncached > icache.
  - On a win: latch owner and address, go to R_BUSY.
- **Read addresses and lengths:**
  - Line reads (ic/dc): `bus_raddr_o` = {addr[31:4], 4'b0}, `bus_rlen_o` = 3.
  - Uncached reads: full address, `bus_rlen_o` = 0.
- **`ic_wait`** (3-bit counter):
  - Increments, saturating, each R_IDLE cycle in which `ic_rreq_i`=1, icache is unblocked, and another requester wins.
  - Clears on an icache grant.
- **Hazard:** a read is blocked when its addr[31:4] equals the latched write line while in W_BUSY, or equals the addr[31:4] of a write being granted the same cycle. A blocked read stays pending and does not count toward `ic_wait`.
- **R_BUSY:**
  - `bus_rvalid_i` is routed to the owner's `*_rvalid_o` combinationally.
  - On `bus_rvalid_i & bus_rlast_i`: go to R_IDLE, and pulse the owner's `*_rdone_o` on the next cycle.
- **Write arbitration** (in W_IDLE): dcache > uncached.
  - dcache: line-aligned address, `bus_wlen_o` = 3, `bus_wstrb_o` = 4'hF.
  - uncached: full address, `bus_wlen_o` = 0, `bus_wstrb_o` = `uc_wstrb_i`.
  - Latch all command fields, then go to W_BUSY. In W_BUSY, `bus_bresp_i` returns the FSM to W_IDLE and pulses `*_wdone_o` on the next cycle.
- **Idle-state inputs:** `bus_rvalid_i` is ignored in R_IDLE (no `*_rvalid_o`). `bus_bresp_i` is ignored in W_IDLE.

## Timing
- **Reset:** all outputs are 0, both FSMs idle, `ic_wait` = 0. Reset mid-transfer abandons it with no done pulse; requesters re-request after reset.
- **Read grant:** request sampled in R_IDLE at edge N gives `*_rgnt_o` = 1 for exactly the cycle after N. `bus_rreq_o` is 1 from that cycle until the cycle in which the last beat is accepted, inclusive.
- **Command stability:** `bus_raddr_o`, `bus_rlen_o` and the write command fields are registered and stable throughout BUSY.
- **Back-to-back:** the earliest next read grant comes one cycle after `*_rdone_o`. Minimum gap between reads is one idle cycle.
- **Read-beat path:** `*_rvalid_o` and `rdata_o` are zero-latency from `bus_rvalid_i` and `bus_rdata_i`.
- **Simultaneous events:**
  - A same-line read and write in the same cycle: the write is granted and the read waits for W_IDLE.
  - A read and write to different lines are both granted the same cycle.

## Test plan
- Single icache read 0x1C00_0014 → `ic_rgnt_o` 1 cycle, `bus_raddr_o`=0x1C00_0010, `bus_rlen_o`=3. After 4 beats, `ic_rvalid_o` ×4, then `ic_rdone_o` one cycle after the last beat.
- ic, dc and uc read requests all asserted together → grant order dc, uc, ic. `uc_rgnt_o` sees `bus_rlen_o`=0.
- dcache read requested continuously alongside a held icache request → icache is granted after 7 consecutive losses, and `ic_wait` returns to 0.
- dcache writeback to 0x0000_1230 in W_BUSY plus a dcache read of 0x0000_1238 → read blocked until `bus_bresp_i`. `dc_wdone_o`, then `dc_rgnt_o` two cycles after bresp.
- Uncached store with `uc_wstrb_i`=4'b0011 → `bus_wlen_o`=0, `bus_wstrb_o`=0011, `bus_wsrc_o`=1. A stray `bus_rvalid_i` in R_IDLE produces no `*_rvalid_o`.
- `rst` driven low mid-burst after beat 2 → all outputs 0 and no done pulse. After release, the held request is re-granted.
